sensor_alarm_monitor: RTL and testbench
=======================================

Name: sensor_alarm_monitor

Overview:
- Sequential consumer of the sensor-fault path.
- Samples the 4-bit sensor vector and the combinational `error` flag produced by the sensor fault detector.
- Debounces `error` over a programmable number of cycles, then latches an alarm together with a snapshot of the sensors that caused it.
- Counts qualified events and holds the alarm until the host acknowledges it with `clear`.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive high `error` samples required to qualify an alarm (legal range 1..255)
CNT_WIDTH, 8, width of the qualified-event counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
sensors  input  4  raw sensor vector, same vector driven to the fault detector
error  input  1  fault detector output: sensors[0] | (sensors[1] & (sensors[2] | sensors[3]))
clear  input  1  host acknowledge; single-cycle or level, sampled every cycle
alarm  output  1  latched qualified alarm
alarm_snapshot  output  4  sensor vector captured on the first high sample of the qualified run
event_count  output  CNT_WIDTH  number of qualified alarms since reset, saturating
mismatch  output  1  detector-consistency flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - alarm=0, alarm_snapshot=4'h0, event_count=0, mismatch=0.
  - Internal run counter=0.
  - Reset has priority over every other input, including mid-QUALIFY or ALARM; a pending run is discarded.
- State register encodes IDLE, QUALIFY, ALARM, WAIT_RELEASE. All outputs are registered.
- IDLE:
  - error=1: load run counter=1, capture sensors into a candidate register.
  - Go to ALARM if DEBOUNCE_CYCLES=1, else QUALIFY.
- QUALIFY:
  - error=1: increment run counter. When it reaches DEBOUNCE_CYCLES, go to ALARM.
  - error=0: go to IDLE, clear run counter, leave candidate unused.
- Entry to ALARM (same edge as the transition):
  - alarm<=1, alarm_snapshot<=candidate.
  - event_count<=event_count+1, saturating at all-ones (no wrap).
- Latency: with error high on N=DEBOUNCE_CYCLES consecutive sampled edges, alarm is visible in the cycle after the Nth sampling edge.
- ALARM:
  - alarm held and alarm_snapshot frozen regardless of error or sensors.
  - clear=1 and error=0: alarm<=0, go to IDLE.
  - clear=1 and error=1: alarm<=0, go to WAIT_RELEASE. A continuous fault is counted once.
- WAIT_RELEASE: alarm=0. Stay until error=0, then go to IDLE. A new run may start no earlier than the cycle after returning to IDLE.
- clear outside ALARM is ignored.
- Simultaneous Nth high sample and clear: the edge enters ALARM; clear is not applied on that same edge.
- alarm_snapshot retains its last value after clear until the next qualified alarm overwrites it.

Optional Feature:
- Macro: SENSOR_ALARM_RECHECK_EN.
- Defined:
  - Block recomputes the fault function from sensors internally each cycle.
  - mismatch<=1 on any edge where the recomputed value differs from error.
  - mismatch is sticky until rst or until clear=1 while in IDLE.
  - Qualification still uses the `error` input, not the recomputed value.
- Undefined: no recheck logic; mismatch is tied to 0.

Test Plan:
- Reset, then error=0 for 10 cycles -> alarm=0, event_count=0, alarm_snapshot=0.
- sensors=4'b0001, error=1 for 4 cycles (DEBOUNCE_CYCLES=4) -> alarm=1 in cycle after 4th edge, alarm_snapshot=4'b0001, event_count=1.
- sensors=4'b0110, error high 3 cycles then low, repeated twice -> alarm stays 0, event_count unchanged.
- Alarm active, error still high, clear=1 one cycle -> alarm=0, state WAIT_RELEASE, no new count while error remains high 20 cycles. Then error low 1 cycle, then high 4 cycles -> event_count increments by exactly 1.
- rst=1 asserted in QUALIFY after 2 high samples and again during ALARM -> all outputs 0 on next cycle; a subsequent 4-cycle run needs full 4 samples.
- With SENSOR_ALARM_RECHECK_EN, drive sensors=4'b1010, error=0 -> mismatch=1, sticky until clear in IDLE. Without the macro -> mismatch=0.

Source files
------------

// File: rtl/sensor_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sensor_alarm_monitor
// Description : Debounces the sensor-fault detector output, latches a
//               qualified alarm with a snapshot of the sensors that caused
//               it, counts qualified events (saturating) and holds the alarm
//               until the host acknowledges it with clear.
//               Optional build macro SENSOR_ALARM_RECHECK_EN adds a sticky
//               detector-consistency flag (mismatch); without it mismatch
//               is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_alarm_monitor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sensors,
    input  logic                 error,
    input  logic                 clear,
    output logic                 alarm,
    output logic [3:0]           alarm_snapshot,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 mismatch
);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_QUALIFY      = 2'd1;
    localparam logic [1:0] c_ST_ALARM        = 2'd2;
    localparam logic [1:0] c_ST_WAIT_RELEASE = 2'd3;

    localparam logic [7:0]           c_DEBOUNCE = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [7:0]           r_run;
    logic [7:0]           w_run_next;
    logic [3:0]           r_candidate;
    logic [3:0]           w_candidate_next;
    logic                 r_alarm;
    logic                 w_alarm_next;
    logic [3:0]           r_snapshot;
    logic [3:0]           w_snapshot_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_enter_alarm;

    // State and datapath registers; reset discards any pending run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_run       <= 8'd0;
            r_candidate <= 4'h0;
            r_alarm     <= 1'b0;
            r_snapshot  <= 4'h0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_run       <= w_run_next;
            r_candidate <= w_candidate_next;
            r_alarm     <= w_alarm_next;
            r_snapshot  <= w_snapshot_next;
            r_count     <= w_count_next;
        end
    end

    // Next-state decode: a run of DEBOUNCE_CYCLES high samples qualifies.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (error) begin
                    w_state_next = (c_DEBOUNCE == 8'd1) ? c_ST_ALARM : c_ST_QUALIFY;
                end
            end
            c_ST_QUALIFY: begin
                if (!error) begin
                    w_state_next = c_ST_IDLE;
                end else if ((r_run + 8'd1) == c_DEBOUNCE) begin
                    w_state_next = c_ST_ALARM;
                end
            end
            c_ST_ALARM: begin
                // A fault still present at acknowledge must drop before a
                // new run can start, so a continuous fault counts once.
                if (clear) begin
                    w_state_next = error ? c_ST_WAIT_RELEASE : c_ST_IDLE;
                end
            end
            c_ST_WAIT_RELEASE: begin
                if (!error) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath next values: run counter, candidate, alarm, snapshot, count.
    always_comb begin
        w_run_next       = r_run;
        w_candidate_next = r_candidate;
        w_alarm_next     = r_alarm;
        w_snapshot_next  = r_snapshot;
        w_count_next     = r_count;
        w_enter_alarm    = (r_state != c_ST_ALARM) && (w_state_next == c_ST_ALARM);

        case (r_state)
            c_ST_IDLE: begin
                if (error) begin
                    w_run_next       = 8'd1;
                    w_candidate_next = sensors;
                end
            end
            c_ST_QUALIFY: begin
                w_run_next = error ? (r_run + 8'd1) : 8'd0;
            end
            c_ST_ALARM: begin
                if (clear) begin
                    w_alarm_next = 1'b0;
                end
            end
            default: ;
        endcase

        if (w_enter_alarm) begin
            w_run_next      = 8'd0;
            w_alarm_next    = 1'b1;
            // With a one-sample debounce the candidate is being loaded on
            // this same edge, so take the live sensors instead.
            w_snapshot_next = (r_state == c_ST_IDLE) ? sensors : r_candidate;
            w_count_next    = (&r_count) ? r_count : (r_count + c_CNT_ONE);
        end
    end

    assign alarm          = r_alarm;
    assign alarm_snapshot = r_snapshot;
    assign event_count    = r_count;

`ifdef SENSOR_ALARM_RECHECK_EN
    logic w_recheck;
    logic r_mismatch;

    assign w_recheck = sensors[0] | (sensors[1] & (sensors[2] | sensors[3]));

    // Sticky consistency flag; a fresh disagreement wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_recheck != error) begin
            r_mismatch <= 1'b1;
        end else if (clear && (r_state == c_ST_IDLE)) begin
            r_mismatch <= 1'b0;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_alarm_monitor
// Description : Self-checking bench for sensor_alarm_monitor. Directed
//               vector table, hand-written corner sequences and a random
//               phase compared against a behavioural model. A second
//               instance uses a one-sample debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_alarm_monitor;

    localparam int CW = 8;
`ifdef SENSOR_ALARM_RECHECK_EN
    localparam logic RECHECK = 1'b1;
`else
    localparam logic RECHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    sensors;
    logic          error;
    logic          clear;
    logic          alarm0, alarm1;
    logic [3:0]    snap0, snap1;
    logic [CW-1:0] cnt0, cnt1;
    logic          mm0, mm1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sensor_alarm_monitor #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(CW)) dut0 (
        .clk(clk), .rst(rst), .sensors(sensors), .error(error), .clear(clear),
        .alarm(alarm0), .alarm_snapshot(snap0), .event_count(cnt0), .mismatch(mm0)
    );

    sensor_alarm_monitor #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .rst(rst), .sensors(sensors), .error(error), .clear(clear),
        .alarm(alarm1), .alarm_snapshot(snap1), .event_count(cnt1), .mismatch(mm1)
    );

    // ---------------- behavioural model ----------------
    int            m_deb     [2];
    int            m_run     [2];
    logic          m_alarm   [2];
    logic          m_blocked [2];
    logic [3:0]    m_cand    [2];
    logic [3:0]    m_snap    [2];
    logic [CW-1:0] m_cnt     [2];
    logic          m_mm      [2];

    function automatic logic fault(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

    task automatic model_step(input int k);
        logic idle;
        idle = !m_alarm[k] && !m_blocked[k] && (m_run[k] == 0);
        if (rst) begin
            m_run[k] = 0; m_alarm[k] = 1'b0; m_blocked[k] = 1'b0;
            m_cand[k] = 4'h0; m_snap[k] = 4'h0; m_cnt[k] = '0; m_mm[k] = 1'b0;
        end else begin
            if (RECHECK) begin
                if (fault(sensors) != error) m_mm[k] = 1'b1;
                else if (clear && idle)      m_mm[k] = 1'b0;
            end
            if (m_alarm[k]) begin
                if (clear) begin
                    m_alarm[k]   = 1'b0;
                    m_blocked[k] = error;
                end
            end else if (m_blocked[k]) begin
                if (!error) m_blocked[k] = 1'b0;
            end else if (error) begin
                if (m_run[k] == 0) m_cand[k] = sensors;
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == m_deb[k]) begin
                    m_alarm[k] = 1'b1;
                    m_snap[k]  = m_cand[k];
                    if (m_cnt[k] != {CW{1'b1}}) m_cnt[k] = m_cnt[k] + 1'b1;
                    m_run[k]   = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input logic r, input logic [3:0] s, input logic e, input logic c);
        rst = r; sensors = s; error = e; clear = c;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic a, input logic [3:0] sn,
                         input logic [CW-1:0] cn, input logic mm);
        checks++;
        if (alarm0 !== a || snap0 !== sn || cnt0 !== cn || mm0 !== mm) begin
            errors++;
            $display("FAIL %s: got alarm=%0b snap=%h count=%0d mismatch=%0b, expected alarm=%0b snap=%h count=%0d mismatch=%0b",
                     name, alarm0, snap0, cnt0, mm0, a, sn, cn, mm);
        end
    endtask

    task automatic check_model(input int k);
        logic a; logic [3:0] sn; logic [CW-1:0] cn; logic mm;
        if (k == 0) begin a = alarm0; sn = snap0; cn = cnt0; mm = mm0; end
        else        begin a = alarm1; sn = snap1; cn = cnt1; mm = mm1; end
        checks++;
        if (a !== m_alarm[k] || sn !== m_snap[k] || cn !== m_cnt[k] || mm !== m_mm[k]) begin
            errors++;
            $display("FAIL random_dut%0d: got alarm=%0b snap=%h count=%0d mismatch=%0b, expected alarm=%0b snap=%h count=%0d mismatch=%0b",
                     k, a, sn, cn, mm, m_alarm[k], m_snap[k], m_cnt[k], m_mm[k]);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic          r;
        logic [3:0]    s;
        logic          e;
        logic          c;
        logic          a;
        logic [3:0]    sn;
        logic [CW-1:0] cn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] s, input logic e, input logic c,
                       input logic a, input logic [3:0] sn, input logic [CW-1:0] cn);
        vec_t v;
        v.r = r; v.s = s; v.e = e; v.c = c; v.a = a; v.sn = sn; v.cn = cn;
        tbl.push_back(v);
    endtask

    initial begin
        m_deb[0] = 4;
        m_deb[1] = 1;
        rst = 1'b1; sensors = 4'h0; error = 1'b0; clear = 1'b0;

        // qualify 0001, alarm on 4th sample
        for (int i = 0; i < 3; i++) add(0, 4'h1, 1, 0, 0, 4'h0, 8'd0);
        add(0, 4'h1, 1, 0, 1, 4'h1, 8'd1);
        add(0, 4'h6, 1, 0, 1, 4'h1, 8'd1);          // snapshot frozen
        add(0, 4'h0, 0, 1, 0, 4'h1, 8'd1);          // clear, fault gone
        // two short runs of 3 never qualify
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) add(0, 4'h6, 1, 0, 0, 4'h1, 8'd1);
            add(0, 4'h0, 0, 0, 0, 4'h1, 8'd1);
        end
        // clear held through qualification: ignored, then alarm wins
        for (int i = 0; i < 3; i++) add(0, 4'h3, 1, 1, 0, 4'h1, 8'd1);
        add(0, 4'h3, 1, 1, 1, 4'h3, 8'd2);
        add(0, 4'h5, 1, 0, 1, 4'h3, 8'd2);
        add(0, 4'h5, 1, 1, 0, 4'h3, 8'd2);          // to wait-release
        add(0, 4'h5, 1, 0, 0, 4'h3, 8'd2);
        add(0, 4'h5, 1, 0, 0, 4'h3, 8'd2);
        add(0, 4'h0, 0, 0, 0, 4'h3, 8'd2);          // release
        // snapshot is the first sample of the run
        for (int i = 0; i < 3; i++) add(0, 4'hB, 1, 0, 0, 4'h3, 8'd2);
        add(0, 4'h9, 1, 0, 1, 4'hB, 8'd3);
        add(0, 4'h0, 0, 1, 0, 4'hB, 8'd3);

        // reset state and quiet idle
        step(1, 4'h0, 0, 0);
        check("reset", 0, 4'h0, 8'd0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 4'h0, 0, 0);
            check("idle_quiet", 0, 4'h0, 8'd0, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].c);
            check($sformatf("vec%0d", i), tbl[i].a, tbl[i].sn, tbl[i].cn, 1'b0);
        end

        // continuous fault counted once across a long wait-release
        for (int i = 0; i < 4; i++) step(0, 4'h1, 1, 0);
        check("alarm4", 1, 4'h1, 8'd4, 0);
        step(0, 4'h1, 1, 1);
        check("clear_hold", 0, 4'h1, 8'd4, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 4'h1, 1, 0);
            check("wait_release", 0, 4'h1, 8'd4, 0);
        end
        step(0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h5, 1, 0);
        check("rerun_3", 0, 4'h1, 8'd4, 0);
        step(0, 4'h5, 1, 0);
        check("rerun_4", 1, 4'h5, 8'd5, 0);
        step(0, 4'h0, 0, 1);

        // reset mid-qualify, then during alarm
        step(0, 4'h1, 1, 0);
        step(0, 4'h1, 1, 0);
        step(1, 4'h1, 1, 0);
        check("rst_qualify", 0, 4'h0, 8'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h3, 1, 0);
        check("post_rst_3", 0, 4'h0, 8'd0, 0);
        step(0, 4'h3, 1, 0);
        check("post_rst_4", 1, 4'h3, 8'd1, 0);
        step(1, 4'h3, 1, 0);
        check("rst_alarm", 0, 4'h0, 8'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h1, 1, 0);
        check("post_rst2_3", 0, 4'h0, 8'd0, 0);
        step(0, 4'h1, 1, 0);
        check("post_rst2_4", 1, 4'h1, 8'd1, 0);
        step(0, 4'h0, 0, 1);

        // mismatch flag: sticky until clear in idle
        step(1, 4'h0, 0, 0);
        step(0, 4'hA, 0, 0);
        check("mismatch_set", 0, 4'h0, 8'd0, RECHECK);
        step(0, 4'h0, 0, 0);
        check("mismatch_sticky", 0, 4'h0, 8'd0, RECHECK);
        step(0, 4'h0, 0, 1);
        check("mismatch_clear", 0, 4'h0, 8'd0, 0);

        // event counter saturates at all-ones
        step(1, 4'h0, 0, 0);
        for (int n = 0; n < 258; n++) begin
            for (int i = 0; i < 4; i++) step(0, 4'h1, 1, 0);
            check("saturate", 1, 4'h1, (n + 1 > 255) ? 8'd255 : 8'(n + 1), 0);
            step(0, 4'h0, 0, 1);
        end

        // random phase against the model, both debounce settings
        step(1, 4'h0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] s;
            logic       e;
            s = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 19) == 0) ? ~fault(s) : fault(s);
            step(($urandom_range(0, 99) == 0), s, e, ($urandom_range(0, 6) == 0));
            check_model(0);
            check_model(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
